// File: rtl/perf_counter_sampler.sv
// perf_counter_sampler: shares the performance-counter port between the CSR
// file and a snapshot scanner. The scanner copies every counter (optionally
// clearing it) into a record FIFO that drains over a valid/ready stream.
module perf_counter_sampler #(
    parameter int NUM_COUNTERS = 14,
    parameter int BASE_ADDR    = 3,
    parameter int XLEN         = 64,
    parameter int FIFO_DEPTH   = 32,
    parameter int PERIOD_W     = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                csr_req_i,
    input  logic [4:0]          csr_addr_i,
    input  logic                csr_we_i,
    input  logic [XLEN-1:0]     csr_wdata_i,
    output logic [XLEN-1:0]     csr_rdata_o,
    output logic [4:0]          pc_addr_o,
    output logic                pc_we_o,
    output logic [XLEN-1:0]     pc_wdata_o,
    input  logic [XLEN-1:0]     pc_rdata_i,
    input  logic                enable_i,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic                trigger_i,
    input  logic                clear_on_sample_i,
    output logic                snap_valid_o,
    input  logic                snap_ready_i,
    output logic [XLEN-1:0]     snap_data_o,
    output logic [4:0]          snap_idx_o,
    output logic                snap_last_o,
    output logic [7:0]          snap_seq_o,
    output logic                busy_o,
    output logic [15:0]         dropped_o
);

    // Record layout: {data, idx[4:0], last, seq[7:0]}
    localparam int REC_W = XLEN + 14;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [4:0]         r_idx;
    logic [4:0]         w_idx_next;
    logic [7:0]         r_seq;
    logic [7:0]         w_seq_next;
    logic               r_pending;
    logic               w_pending_next;
    logic [15:0]        r_dropped;
    logic [15:0]        w_dropped_next;
    logic [PERIOD_W-1:0] r_timer;

    logic [REC_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_timer_run;
    logic               w_timer_req;
    logic               w_req;
    logic               w_push;
    logic               w_pop;
    logic               w_last;
    logic [CNT_W-1:0]   w_free;
    logic [REC_W-1:0]   w_push_rec;
    logic [REC_W-1:0]   w_head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_timer_run = enable_i && (period_i != '0);
    assign w_timer_req = w_timer_run && (r_timer >= period_i - PERIOD_W'(1));
    assign w_req       = trigger_i | w_timer_req;
    assign w_last      = (r_idx == 5'(NUM_COUNTERS - 1));
    assign w_free      = CNT_W'(FIFO_DEPTH) - r_count;
    assign w_push_rec  = {pc_rdata_i, r_idx, w_last, r_seq};

    // Period timer: free-runs while enabled, wrapping at period_i-1 with a request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_timer <= '0;
        end else if (w_timer_run) begin
            r_timer <= w_timer_req ? '0 : r_timer + PERIOD_W'(1);
        end else begin
            r_timer <= '0;
        end
    end

    // Scanner state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_seq     <= '0;
            r_pending <= 1'b0;
            r_dropped <= '0;
        end else begin
            r_state   <= w_state_next;
            r_idx     <= w_idx_next;
            r_seq     <= w_seq_next;
            r_pending <= w_pending_next;
            r_dropped <= w_dropped_next;
        end
    end

    // Scanner next-state: requests only latch while idle; a scan absorbs any
    // request that arrives while it runs.
    always_comb begin
        w_state_next   = r_state;
        w_idx_next     = r_idx;
        w_seq_next     = r_seq;
        w_pending_next = r_pending;
        w_dropped_next = r_dropped;
        w_push         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_pending) begin
                    w_pending_next = 1'b0;
                    if (w_free >= CNT_W'(NUM_COUNTERS)) begin
                        w_idx_next   = '0;
                        w_state_next = ST_SCAN;
                    end else if (r_dropped != 16'hFFFF) begin
                        w_dropped_next = r_dropped + 16'd1;
                    end
                end else begin
                    w_pending_next = w_req;
                end
            end
            ST_SCAN: begin
                w_pending_next = 1'b0;
                if (!csr_req_i) begin
                    w_push = 1'b1;
                    if (w_last) begin
                        w_idx_next   = '0;
                        w_seq_next   = r_seq + 8'd1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_idx_next = r_idx + 5'd1;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Counter-port mux: the CSR file always wins; the scanner stalls meanwhile.
    always_comb begin
        csr_rdata_o = pc_rdata_i;
        if (csr_req_i) begin
            pc_addr_o  = csr_addr_i;
            pc_we_o    = csr_we_i;
            pc_wdata_o = csr_wdata_i;
        end else begin
            pc_addr_o  = 5'(BASE_ADDR) + r_idx;
            pc_we_o    = (r_state == ST_SCAN) && clear_on_sample_i;
            pc_wdata_o = '0;
        end
    end

    assign w_pop        = snap_valid_o && snap_ready_i;
    assign snap_valid_o = (r_count != '0);
    assign w_head       = r_mem[r_rd_ptr];
    assign snap_data_o  = w_head[REC_W-1 -: XLEN];
    assign snap_idx_o   = w_head[13:9];
    assign snap_last_o  = w_head[8];
    assign snap_seq_o   = w_head[7:0];
    assign busy_o       = (r_state == ST_SCAN);
    assign dropped_o    = r_dropped;

    // Record storage: write-only array; head entry is read by the output mux.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_rec;
        end
    end

    // FIFO pointers and occupancy; reserved space at scan start prevents overflow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            assert (!(w_push && !w_pop && (r_count == CNT_W'(FIFO_DEPTH))));
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
